sdram_request_arbiter: RTL
==========================

Name: sdram_request_arbiter

Overview:
- Front-end that sits directly upstream of the AS4C4M16SA SDRAM controller.
- Two clients (port 0, port 1) issue single-word write or burst-read requests over valid/ready handshakes.
- Requests are granted round-robin and translated into the controller's level-held command interface.
- Each controller completion pulse is routed back to the requesting client as a write acknowledge or a read-data stream.

Parameters:
- READ_BURST_LENGTH, 1: beats per read; must equal the controller's setting (1, 2, 4 or 8). The controller runs with WRITE_BURST=0, so writes are always one word.
- QUIET_CYCLES, 64: cycles after reset deassertion during which no request is accepted. This lets any controller operation in flight drain.

Ports:
- clk  in  1  system clock, same clock as the controller
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  2  per-client request valid
- req_ready  out  2  per-client accept; one-hot or zero
- req_write  in  2  per-client type: 1=write, 0=read
- req_address  in  2x22  per-client word address (bank[21:20], row[19:8], col[7:0])
- req_wdata  in  2x16  per-client write data
- wr_ack  out  2  one-cycle pulse: write committed for that client
- rd_valid  out  2  per-client read beat valid; no backpressure
- rd_last  out  1  high with the final beat of a read burst
- rd_data  out  16  read beat data, shared by both clients
- command  out  2  to controller: 0 idle, 1 write, 2 read
- data_address  out  22  to controller
- data_write  out  16  to controller
- data_read  in  16  from controller
- data_read_valid  in  1  from controller
- data_write_done  in  1  from controller

Behaviour:
- Reset (async assert, sync release):
  - command=0, req_ready=0, wr_ack=0, rd_valid=0, rd_last=0.
  - rd_data=0, data_address=0, data_write=0.
  - State=QUIET, quiet counter=QUIET_CYCLES-1, rr pointer=0.
- QUIET:
  - Counter decrements each cycle; all controller inputs are ignored.
  - At counter 0 the block enters IDLE.
- IDLE:
  - If any req_valid, grant one client:
    - Only one valid: that client wins.
    - Both valid: client == rr pointer wins.
  - In the grant cycle, req_ready[g]=1 (combinational from state, valids and rr pointer).
  - Registered on that edge: data_address, data_write, command (write?1:2), owner=g, rr pointer=~g. State becomes ISSUE.
  - At most one req_ready bit is high, and only in IDLE.
- ISSUE:
  - command, data_address and data_write are held stable. The controller samples them only when it is idle, so holding covers refresh and post-op recovery windows.
  - Write owner, data_write_done=1: command<=0; wr_ack[owner] pulses next cycle; go to IDLE.
  - Read owner, data_read_valid=1: command<=0; forward the beat; beat counter=1.
    - If READ_BURST_LENGTH==1, go to IDLE.
    - Otherwise go to READ.
  - Completion pulses of the wrong type while in ISSUE are ignored.
- READ:
  - Each cycle with data_read_valid=1: forward the beat and increment the beat counter.
  - When the counter reaches READ_BURST_LENGTH, go to IDLE.
  - If data_read_valid drops before the burst completes, stay in READ (controller beats are contiguous, so this should not occur).
- Beat forwarding is registered, one cycle of latency:
  - rd_data<=data_read.
  - rd_valid<=one-hot(owner).
  - rd_last<=(beat is number READ_BURST_LENGTH).
- Latency:
  - Request grant to command driven: 1 cycle.
  - data_write_done to wr_ack: 1 cycle.
  - data_read_valid to rd_valid: 1 cycle.
- Command must be 0 by the cycle after the first completion pulse. The controller's post-op wait (≥2 cycles) guarantees it never re-samples the old command.
- A new grant may occur in the cycle after returning to IDLE. Its command simply waits for the controller to reach idle.
- Reset mid-operation: all outputs return to reset values immediately, and the block re-enters QUIET. Controller pulses arriving during QUIET are dropped.
- Beat counter width is clog2(READ_BURST_LENGTH+1). rr pointer is 1 bit.

Test Plan:
- Reset release, req_valid=2'b01 at cycle 10, QUIET_CYCLES=64 -> req_ready stays 0 until QUIET ends, then req_ready=2'b01. Next cycle command=1 or 2 per req_write.
- Client0 write addr 22'h3ABCDE, data 16'hBEEF, with the controller model -> data_address=22'h3ABCDE, data_write=16'hBEEF, command=1.
  - Command held until data_write_done.
  - command=0 the next cycle.
  - wr_ack=2'b01 for exactly 1 cycle.
- Both clients valid continuously, reads, READ_BURST_LENGTH=4 -> grants alternate 0,1,0,1.
  - Each burst gives 4 rd_valid beats one-hot to the owner, rd_last on beat 4.
  - Data matches the model pattern 16'h1000+beat.
- Controller model inserts a refresh (command ignored for 9 cycles) before accepting a read -> command stays 2 and address stays stable throughout. Exactly one read is performed.
- reset_n asserted during the second beat of a 4-beat read -> rd_valid=0 immediately. No further rd_valid or wr_ack until QUIET_CYCLES have elapsed after release.
- Stray data_write_done while a read is owned -> ignored: no wr_ack, state unchanged.

Source files
------------

// File: rtl/sdram_request_arbiter_if.sv
// Client-side request/response bundle for the two-port SDRAM front-end.
// Clients drive the master modport; the arbiter drives the slave modport.
interface sdram_request_arbiter_if;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_write;
    logic [1:0][21:0] req_address;
    logic [1:0][15:0] req_wdata;
    logic [1:0]       wr_ack;
    logic [1:0]       rd_valid;
    logic             rd_last;
    logic [15:0]      rd_data;

    modport master (
        output req_valid, req_write, req_address, req_wdata,
        input  req_ready, wr_ack, rd_valid, rd_last, rd_data
    );

    modport slave (
        input  req_valid, req_write, req_address, req_wdata,
        output req_ready, wr_ack, rd_valid, rd_last, rd_data
    );
endinterface

// File: rtl/sdram_request_arbiter.sv
// Round-robin two-client arbiter in front of the AS4C4M16SA controller.
// It turns valid/ready requests into a level-held command and routes completions back.
module sdram_request_arbiter #(
    parameter int READ_BURST_LENGTH = 1,
    parameter int QUIET_CYCLES      = 64
) (
    input  logic                    clk,
    input  logic                    reset_n,
    sdram_request_arbiter_if.slave  bus,
    output logic [1:0]              command,
    output logic [21:0]             data_address,
    output logic [15:0]             data_write,
    input  logic [15:0]             data_read,
    input  logic                    data_read_valid,
    input  logic                    data_write_done
);
    localparam int QW = (QUIET_CYCLES > 1) ? $clog2(QUIET_CYCLES) : 1;
    localparam int BW = $clog2(READ_BURST_LENGTH + 1);
    localparam logic [QW-1:0] QUIET_INIT = QW'(QUIET_CYCLES - 1);
    localparam logic [BW-1:0] BURST_LEN  = BW'(READ_BURST_LENGTH);
    localparam logic [1:0] CMD_IDLE = 2'd0;
    localparam logic [1:0] CMD_WR   = 2'd1;
    localparam logic [1:0] CMD_RD   = 2'd2;

    typedef enum logic [1:0] {QUIET, IDLE, ISSUE, READ} state_t;

    state_t        state, state_nx;
    logic [QW-1:0] quiet_cnt, quiet_cnt_nx;
    logic [BW-1:0] beat_cnt, beat_cnt_nx, beat_inc;
    logic          rr, owner, owner_wr;
    logic          grant, load_req, clr_cmd, ack_wr, fwd_beat, beat_last;
    logic [1:0]    wr_ack_q, rd_valid_q;
    logic          rd_last_q;
    logic [15:0]   rd_data_q;

    assign bus.wr_ack   = wr_ack_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_last  = rd_last_q;
    assign bus.rd_data  = rd_data_q;

    // Lone requester always wins; on a tie the rr pointer picks.
    assign grant    = bus.req_valid[1] & (~bus.req_valid[0] | rr);
    assign beat_inc = beat_cnt + 1'b1;

    always_comb begin
        state_nx      = state;
        quiet_cnt_nx  = quiet_cnt;
        beat_cnt_nx   = beat_cnt;
        bus.req_ready = '0;
        load_req      = 1'b0;
        clr_cmd       = 1'b0;
        ack_wr        = 1'b0;
        fwd_beat      = 1'b0;
        beat_last     = 1'b0;
        case (state)
            QUIET: begin
                if (quiet_cnt == '0) state_nx = IDLE;
                else                 quiet_cnt_nx = quiet_cnt - 1'b1;
            end
            IDLE: begin
                if (|bus.req_valid) begin
                    bus.req_ready[grant] = 1'b1;
                    load_req             = 1'b1;
                    state_nx             = ISSUE;
                end
            end
            ISSUE: begin
                // Completions of the other type are stray and dropped.
                if (owner_wr && data_write_done) begin
                    clr_cmd  = 1'b1;
                    ack_wr   = 1'b1;
                    state_nx = IDLE;
                end else if (!owner_wr && data_read_valid) begin
                    clr_cmd     = 1'b1;
                    fwd_beat    = 1'b1;
                    beat_cnt_nx = BW'(1);
                    beat_last   = (BURST_LEN == BW'(1));
                    state_nx    = beat_last ? IDLE : READ;
                end
            end
            READ: begin
                if (data_read_valid) begin
                    fwd_beat    = 1'b1;
                    beat_cnt_nx = beat_inc;
                    beat_last   = (beat_inc == BURST_LEN);
                    if (beat_last) state_nx = IDLE;
                end
            end
            default: state_nx = QUIET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= QUIET;
            quiet_cnt <= QUIET_INIT;
            beat_cnt  <= '0;
        end else begin
            state     <= state_nx;
            quiet_cnt <= quiet_cnt_nx;
            beat_cnt  <= beat_cnt_nx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr           <= 1'b0;
            owner        <= 1'b0;
            owner_wr     <= 1'b0;
            command      <= CMD_IDLE;
            data_address <= '0;
            data_write   <= '0;
            wr_ack_q     <= '0;
            rd_valid_q   <= '0;
            rd_last_q    <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            wr_ack_q   <= ack_wr   ? {owner, ~owner} : 2'b00;
            rd_valid_q <= fwd_beat ? {owner, ~owner} : 2'b00;
            rd_last_q  <= fwd_beat & beat_last;
            if (fwd_beat) rd_data_q <= data_read;
            // Command stays level-held until its completion; the controller samples it when idle.
            if (load_req) begin
                data_address <= bus.req_address[grant];
                data_write   <= bus.req_wdata[grant];
                command      <= bus.req_write[grant] ? CMD_WR : CMD_RD;
                owner        <= grant;
                owner_wr     <= bus.req_write[grant];
                rr           <= ~grant;
            end else if (clr_cmd) begin
                command <= CMD_IDLE;
            end
        end
    end
endmodule
